brc_arbiter: RTL and testbench

BRC_ARBITER -- requirements
Module: brc_arbiter

---
 rtl/brc_arbiter.sv | 146 ++++++++++++++
 tb/tb_brc_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/brc_arbiter.sv
// brc_arbiter: two requesters share one 32-bit comparator.
//
// Requester 0 is the branch unit and can be squashed by flush. Requester 1 is
// the ALU SLT/SLTU path. One request is accepted at a time. Its eq/lt result
// is registered and then presented on that requester's response port until
// the requester consumes it.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   flush                    squash requester 0 (blocks its grant, drops RESP0)
//   reqN_valid/a/b/unsigned  operand pair and compare mode from requester N
//   reqN_ready               request N accepted this cycle (combinational)
//   rspN_valid/eq/lt         registered result for requester N
//   rspN_ready               requester N consumes its response
//
// Configuration
//   BRC_ARB_FIXED_PRIO_EN    when defined, requester 0 always wins contention
//                            and no last-grant pointer is kept. The default is
//                            round-robin.
module brc_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_unsigned,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic        rsp0_eq,
  output logic        rsp0_lt,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_unsigned,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic        rsp1_eq,
  output logic        rsp1_lt,
  input  logic        rsp1_ready
);

  typedef enum logic [1:0] {StIdle, StResp0, StResp1} state_e;

  state_e state_q, state_d;
  logic   eq_q, lt_q;
  logic   grant0, grant1;
  logic   cand0, cand1;

  logic [31:0] op_a, op_b;
  logic        op_unsigned;
  logic        cmp_eq, cmp_lt;

`ifndef BRC_ARB_FIXED_PRIO_EN
  // 1 = requester 1 was granted last, so requester 0 wins the next contention.
  logic last_q;
`endif

  // Grants are only issued in IDLE and never while reset is asserted.
  // A flush removes requester 0 from arbitration for that cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    cand0  = req0_valid && !flush;
    cand1  = req1_valid;
    if (state_q == StIdle && !rst) begin
      if (cand0 && cand1) begin
`ifdef BRC_ARB_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        grant0 = last_q;
        grant1 = !last_q;
`endif
      end else begin
        grant0 = cand0;
        grant1 = cand1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The single shared comparator reads the granted requester's operands.
  always_comb begin
    op_a        = grant1 ? req1_a : req0_a;
    op_b        = grant1 ? req1_b : req0_b;
    op_unsigned = grant1 ? req1_unsigned : req0_unsigned;
    cmp_eq      = (op_a == op_b);
    cmp_lt      = op_unsigned ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant0)      state_d = StResp0;
        else if (grant1) state_d = StResp1;
      end
      StResp0: begin
        if (flush || rsp0_ready) state_d = StIdle;
      end
      StResp1: begin
        if (rsp1_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        eq_q <= cmp_eq;
        lt_q <= cmp_lt;
      end
    end
  end

`ifndef BRC_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (grant0) begin
      last_q <= 1'b0;
    end else if (grant1) begin
      last_q <= 1'b1;
    end
  end
`endif

  // Only one request is in flight at a time, so both response ports can
  // share one result register pair.
  assign rsp0_valid = (state_q == StResp0);
  assign rsp1_valid = (state_q == StResp1);
  assign rsp0_eq    = eq_q;
  assign rsp0_lt    = lt_q;
  assign rsp1_eq    = eq_q;
  assign rsp1_lt    = lt_q;

endmodule

// File: tb/tb_brc_arbiter.sv
// Randomized bench for brc_arbiter. A transaction-level reference model
// tracks which requester owns the pending response, the round-robin history
// and the expected compare result.
module tb_brc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_unsigned, req1_unsigned;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_eq, rsp0_lt, rsp1_eq, rsp1_lt;
  logic        rsp0_ready, rsp1_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  brc_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_unsigned(req0_unsigned),
    .req0_ready   (req0_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_eq      (rsp0_eq),
    .rsp0_lt      (rsp0_lt),
    .rsp0_ready   (rsp0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_unsigned(req1_unsigned),
    .req1_ready   (req1_ready),
    .rsp1_valid   (rsp1_valid),
    .rsp1_eq      (rsp1_eq),
    .rsp1_lt      (rsp1_lt),
    .rsp1_ready   (rsp1_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operands biased toward signed/unsigned boundaries.
  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model state.
  int pending;      // -1 = no response outstanding, otherwise owning requester
  int last_grant;   // requester granted most recently
  bit exp_eq, exp_lt;

  function automatic bit model_lt(input logic [31:0] a, input logic [31:0] b, input bit uns);
    longint sa, sb;
    if (uns) return longint'({32'h0, a}) < longint'({32'h0, b});
    sa = a[31] ? longint'({32'h0, a}) - 64'sd4294967296 : longint'({32'h0, a});
    sb = b[31] ? longint'({32'h0, b}) - 64'sd4294967296 : longint'({32'h0, b});
    return sa < sb;
  endfunction

  initial begin
    int  winner;
    bit  c0, c1;

    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_unsigned = 1'b0; req1_unsigned = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_rsp1_valid", rsp1_valid, 0);
    check("reset_result", {rsp0_eq, rsp0_lt, rsp1_eq, rsp1_lt}, 0);
    pending = -1;
    last_grant = 1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst           = (cyc == 0) ? 1'b0 : ($urandom_range(0, 99) < 2);
      flush         = ($urandom_range(0, 99) < 15);
      req0_valid    = ($urandom_range(0, 99) < 70);
      req1_valid    = ($urandom_range(0, 99) < 70);
      req0_a        = pick_operand();
      req0_b        = ($urandom_range(0, 3) == 0) ? req0_a : pick_operand();
      req1_a        = pick_operand();
      req1_b        = ($urandom_range(0, 3) == 0) ? req1_a : pick_operand();
      req0_unsigned = $urandom_range(0, 1);
      req1_unsigned = $urandom_range(0, 1);
      rsp0_ready    = ($urandom_range(0, 99) < 60);
      rsp1_ready    = ($urandom_range(0, 99) < 60);
      #1;

      // Expected grant this cycle.
      winner = -1;
      if (!rst && pending == -1) begin
        c0 = req0_valid && !flush;
        c1 = req1_valid;
        if (c0 && c1) begin
`ifdef BRC_ARB_FIXED_PRIO_EN
          winner = 0;
`else
          winner = (last_grant == 0) ? 1 : 0;
`endif
        end else if (c0) begin
          winner = 0;
        end else if (c1) begin
          winner = 1;
        end
      end

      check("req0_ready", req0_ready, winner == 0);
      check("req1_ready", req1_ready, winner == 1);
      check("rsp0_valid", rsp0_valid, pending == 0);
      check("rsp1_valid", rsp1_valid, pending == 1);
      if (pending == 0) begin
        check("rsp0_eq", rsp0_eq, exp_eq);
        check("rsp0_lt", rsp0_lt, exp_lt);
      end
      if (pending == 1) begin
        check("rsp1_eq", rsp1_eq, exp_eq);
        check("rsp1_lt", rsp1_lt, exp_lt);
      end

      // Advance the model to the state after the coming clock edge.
      if (rst) begin
        pending    = -1;
        last_grant = 1;
      end else if (pending == -1) begin
        if (winner == 0) begin
          exp_eq = (req0_a == req0_b);
          exp_lt = model_lt(req0_a, req0_b, req0_unsigned);
        end else if (winner == 1) begin
          exp_eq = (req1_a == req1_b);
          exp_lt = model_lt(req1_a, req1_b, req1_unsigned);
        end
        if (winner >= 0) begin
          pending    = winner;
          last_grant = winner;
        end
      end else if (pending == 0) begin
        if (flush || rsp0_ready) pending = -1;
      end else begin
        if (rsp1_ready) pending = -1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
